fifo_push_arb: RTL and testbench

- Round-robin arbiter that shares the single push port of the team's fifo block among NUM_REQ requesters.
- Each requester presents a word with a req/gnt handshake; the arbiter picks one winner per cycle and drives fifo push/data_in.
- Never pushes while the FIFO reports full.
- Tracks back-pressure and FIFO error status for software/debug.

---
 rtl/fifo_push_arb.sv | 206 ++++++++++++++++++++
 tb/tb_fifo_push_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arb.sv
// rtl/fifo_push_arb.sv - round-robin arbiter sharing the fifo push port among NUM_REQ requesters
//
// Purpose:
//   Picks one requester per cycle (round robin starting at rr_ptr) and forwards
//   its word to the fifo push port. Never pushes while fifo_full is high. Keeps
//   a saturating stall counter, a wrapping accept counter and a sticky copy of
//   the fifo error flag.
//
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   req, req_data     per-requester word valid and packed words (slot i at [i*DATA_W +: DATA_W])
//   req_lock          per-requester burst lock request (burst build only)
//   gnt               one-hot grant; a word is taken when req[i] && gnt[i]
//   fifo_push         push strobe to the fifo
//   fifo_data_in      granted word, zero when nothing is granted
//   fifo_full         fifo full flag
//   fifo_error        fifo error flag
//   clr               synchronous clear of stall_cnt, accept_cnt, err_sticky
//   stall_cnt         saturating count of cycles with any req while full
//   accept_cnt        wrapping count of accepted words
//   err_sticky        set by fifo_error, cleared by clr
//
// Build option:
//   FIFO_ARB_BURST_EN  when defined, a winner holding req_lock keeps the grant
//                      for up to BURST_MAX consecutive words (HOLD state).

module fifo_push_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      fifo_push,
  output logic [DATA_W-1:0]         fifo_data_in,
  input  logic                      fifo_full,
  input  logic                      fifo_error,
  input  logic                      clr,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          accept_cnt,
  output logic                      err_sticky
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   accept_cnt_q, accept_cnt_d;
  logic               err_sticky_q, err_sticky_d;

  logic [PTR_W-1:0]   winner;
  logic               winner_vld;
  logic [PTR_W-1:0]   sel;
  logic               sel_vld;
  logic [NUM_REQ-1:0] gnt_int;
  logic               accept;

`ifdef FIFO_ARB_BURST_EN
  localparam int BCNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [BCNT_W-1:0]  burst_cnt_q, burst_cnt_d;
`else
  logic               unused_cfg;
  assign unused_cfg = (^req_lock) ^ (BURST_MAX < 1);
`endif

  // Increment modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [PTR_W-1:0] idx;
    winner     = '0;
    winner_vld = 1'b0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(rr_ptr_q) + k >= NUM_REQ) idx = PTR_W'(int'(rr_ptr_q) + k - NUM_REQ);
      else                               idx = PTR_W'(int'(rr_ptr_q) + k);
      if (!winner_vld && req[idx]) begin
        winner     = idx;
        winner_vld = 1'b1;
      end
    end
  end

  // Grant selection. reset_n gates the grant directly so that asserting reset
  // mid-transfer kills the push in the same cycle, not at the next edge.
  always_comb begin
    sel     = winner;
    sel_vld = winner_vld;
`ifdef FIFO_ARB_BURST_EN
    if (state_q == HOLD) begin
      sel     = owner_q;
      sel_vld = req[owner_q];
    end
`endif
    gnt_int = '0;
    if (reset_n && !fifo_full && sel_vld) gnt_int[sel] = 1'b1;
  end

  assign accept = |gnt_int;

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_int[i]) fifo_data_in = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Status counters; clr wins over a same-cycle increment or error set.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    accept_cnt_d = accept_cnt_q;
    err_sticky_d = err_sticky_q;
    if (clr) begin
      stall_cnt_d  = '0;
      accept_cnt_d = '0;
      err_sticky_d = 1'b0;
    end else begin
      if ((|req) && fifo_full && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (accept)     accept_cnt_d = accept_cnt_q + 1'b1;
      if (fifo_error) err_sticky_d = 1'b1;
    end
  end

  // Pointer and burst state next-state logic.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
`ifdef FIFO_ARB_BURST_EN
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == HOLD) begin
      if (!req[owner_q]) begin
        // Owner went idle: release the lock without taking a word.
        state_d     = ARB;
        rr_ptr_d    = ptr_inc(owner_q);
        burst_cnt_d = '0;
      end else if (accept) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
        rr_ptr_d    = ptr_inc(owner_q);
        if ((burst_cnt_d == BCNT_W'(BURST_MAX)) || !req_lock[owner_q]) begin
          state_d     = ARB;
          burst_cnt_d = '0;
        end
      end
    end else if (accept) begin
      rr_ptr_d = ptr_inc(winner);
      // A one-word burst limit means the first accept already ends the burst.
      if (req_lock[winner] && (BURST_MAX > 1)) begin
        state_d     = HOLD;
        owner_d     = winner;
        burst_cnt_d = BCNT_W'(1);
      end
    end
`else
    if (accept) rr_ptr_d = ptr_inc(winner);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= '0;
      stall_cnt_q  <= '0;
      accept_cnt_q <= '0;
      err_sticky_q <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
      state_q      <= ARB;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
`endif
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      stall_cnt_q  <= stall_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      err_sticky_q <= err_sticky_d;
`ifdef FIFO_ARB_BURST_EN
      state_q      <= state_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
`endif
    end
  end

  assign gnt        = gnt_int;
  assign fifo_push  = accept;
  assign stall_cnt  = stall_cnt_q;
  assign accept_cnt = accept_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_fifo_push_arb.sv
// tb/tb_fifo_push_arb.sv - self-checking bench for fifo_push_arb
//
// Purpose: drives directed and random traffic into fifo_push_arb and compares
//   every output each cycle against a behavioural model of the arbiter rules.
// Ports: none (top-level bench).
// Build option: FIFO_ARB_BURST_EN enables the burst-lock model and directed burst cases.

module tb_fifo_push_arb;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 4;
  localparam int BURST_MAX = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        gnt;
  logic                      fifo_push;
  logic [DATA_W-1:0]         fifo_data_in;
  logic                      fifo_full;
  logic                      fifo_error;
  logic                      clr;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          accept_cnt;
  logic                      err_sticky;

  int checks   = 0;
  int failures = 0;

  fifo_push_arb #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .gnt         (gnt),
    .fifo_push   (fifo_push),
    .fifo_data_in(fifo_data_in),
    .fifo_full   (fifo_full),
    .fifo_error  (fifo_error),
    .clr         (clr),
    .stall_cnt   (stall_cnt),
    .accept_cnt  (accept_cnt),
    .err_sticky  (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  int m_rr    = 0;
  int m_owner = 0;
  int m_bcnt  = 0;
  bit m_hold  = 0;
  int m_stall = 0;
  int m_acc   = 0;
  bit m_err   = 0;

  // Compare process: at each falling edge, predict the combinational outputs
  // from the current inputs, compare everything, then advance the model the
  // way the next rising edge must.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] eg;
    logic [DATA_W-1:0]  ed;
    int                 w;
    bit                 found;
    if (!reset_n) begin
      m_rr = 0; m_owner = 0; m_bcnt = 0; m_hold = 0;
      m_stall = 0; m_acc = 0; m_err = 0;
    end
    eg = '0; ed = '0; w = 0; found = 0;
    if (reset_n && !fifo_full) begin
      if (m_hold) begin
        if (req[m_owner]) begin w = m_owner; found = 1; end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!found && req[(m_rr + k) % NUM_REQ]) begin
            w = (m_rr + k) % NUM_REQ;
            found = 1;
          end
        end
      end
    end
    if (found) begin
      eg[w] = 1'b1;
      ed    = req_data[w*DATA_W +: DATA_W];
    end
    check("gnt", 32'(gnt), 32'(eg));
    check("fifo_push", 32'(fifo_push), 32'(found));
    check("fifo_data_in", 32'(fifo_data_in), 32'(ed));
    check("stall_cnt", 32'(stall_cnt), m_stall);
    check("accept_cnt", 32'(accept_cnt), m_acc);
    check("err_sticky", 32'(err_sticky), 32'(m_err));

    if (reset_n) begin
      if (clr) begin
        m_stall = 0; m_acc = 0; m_err = 0;
      end else begin
        if (req != 0 && fifo_full && m_stall < CNT_MAX) m_stall++;
        if (found) m_acc = (m_acc + 1) % (CNT_MAX + 1);
        if (fifo_error) m_err = 1;
      end
`ifdef FIFO_ARB_BURST_EN
      if (m_hold) begin
        if (!req[m_owner]) begin
          m_hold = 0;
          m_rr   = (m_owner + 1) % NUM_REQ;
        end else if (found) begin
          m_bcnt++;
          m_rr = (m_owner + 1) % NUM_REQ;
          if (m_bcnt == BURST_MAX || !req_lock[m_owner]) m_hold = 0;
        end
      end else if (found) begin
        m_rr = (w + 1) % NUM_REQ;
        if (req_lock[w] && BURST_MAX > 1) begin
          m_hold = 1; m_owner = w; m_bcnt = 1;
        end
      end
`else
      if (found) m_rr = (w + 1) % NUM_REQ;
`endif
    end
  end

  // Apply a new input set 1 time unit after the rising edge; returns 3 units
  // after the edge so callers can sample combinational outputs.
  task automatic step(input logic [3:0] r, input logic [3:0] lk,
                      input logic f, input logic e, input logic c);
    @(posedge clk);
    #1;
    req        = r;
    req_lock   = lk;
    fifo_full  = f;
    fifo_error = e;
    clr        = c;
    req_data   = $urandom;
    #2;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    #2;
  endtask

  logic [3:0] seq_rr [8];
  logic [3:0] r_rand;
  logic [3:0] lk_rand;

  initial begin
    seq_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset_n = 1'b0; req = 4'b1111; req_data = 32'h11223344; req_lock = '0;
    fifo_full = 1'b0; fifo_error = 1'b0; clr = 1'b0;

    repeat (2) @(posedge clk);
    #3;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_push", 32'(fifo_push), 0);
    @(posedge clk); #1 reset_n = 1'b1; req = '0;
    #2;
    check("rst_accept_cnt", 32'(accept_cnt), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_err_sticky", 32'(err_sticky), 0);

    // All requesters active: strict rotation.
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
      check("rot_gnt", 32'(gnt), 32'(seq_rr[i]));
    end

    // Sparse requesters 1 and 3 from rr_ptr=0.
    step(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rot_accept_cnt", 32'(accept_cnt), 8);
    check("sparse_gnt0", 32'(gnt), 32'h2);
    step(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("sparse_gnt1", 32'(gnt), 32'h8);
    step(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("sparse_gnt2", 32'(gnt), 32'h2);

    // Full stall, then release grants in the same cycle.
    for (int i = 0; i < 5; i++) begin
      step(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
      check("full_gnt", 32'(gnt), 0);
      check("full_push", 32'(fifo_push), 0);
    end
    step(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("full_stall_cnt", 32'(stall_cnt), 5);
    check("full_release_gnt", 32'(gnt), 32'h1);

    // Error pulse and clear with a concurrent stall.
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("err_not_yet", 32'(err_sticky), 0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("err_set", 32'(err_sticky), 1);
    step(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1);
    check("err_stays", 32'(err_sticky), 1);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("clr_stall_cnt", 32'(stall_cnt), 0);
    check("clr_err_sticky", 32'(err_sticky), 0);
    check("clr_accept_cnt", 32'(accept_cnt), 0);

    // Stall counter saturation.
    for (int i = 0; i < 20; i++) step(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("stall_saturate", 32'(stall_cnt), CNT_MAX);

    // Accept counter wrap: 20 accepts on a 4-bit counter.
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("accept_wrap", 32'(accept_cnt), 4);

    // Reset in the middle of traffic.
    step(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 reset_n = 1'b0;
    #2;
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_push", 32'(fifo_push), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    #2;
    check("midrst_first_gnt", 32'(gnt), 32'h1);

`ifdef FIFO_ARB_BURST_EN
    // Locked burst runs to BURST_MAX, then hands over.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      step(4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0);
      check("burst_gnt", 32'(gnt), 32'h1);
    end
    step(4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0);
    check("burst_handover", 32'(gnt), 32'h2);
    // Lock dropped on the second accept: handover after two words.
    reset_pulse();
    step(4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0);
    check("unlock_gnt0", 32'(gnt), 32'h1);
    step(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("unlock_gnt1", 32'(gnt), 32'h1);
    step(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("unlock_handover", 32'(gnt), 32'h2);
`endif

    // Random traffic checked by the model.
    for (int n = 0; n < 3000; n++) begin
      r_rand  = 4'($urandom);
      lk_rand = 4'($urandom);
      if ($urandom_range(0, 299) == 0) reset_pulse();
      step(r_rand, lk_rand,
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 39) == 0));
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
